// File: rtl/pipe_field.sv
// pipe_field: N-channel scrolling pipe obstacles for the Flappy Bird VGA path.
// Moves N_PIPES pipes left by `speed` pixels on each frame_tick while the game
// runs. Pipes that leave the screen wrap around by N_PIPES*SPACING and get a new
// gap height from an LFSR. The module also detects pipes passing the bird
// column, keeps a saturating score, and produces a registered pipe pixel.
//
// Ports:
//   clk, reset        pixel clock, asynchronous active-high reset
//   frame_tick        one-cycle motion strobe per frame
//   start, halt       game commands (IDLE->RUN / HALT->IDLE, RUN->HALT)
//   speed[3:0]        pixels per motion step, sampled on the tick
//   hCount, vCount    current scan position
//   pipe_pixel        registered: scan position lies on a pipe body
//   pass_pulse        one-cycle pulse when at least one pipe passed BIRD_X
//   score[9:0]        pipes passed, saturating at 999
//   state[1:0]        00 IDLE, 01 RUN, 10 HALT
module pipe_field #(
    parameter int          N_PIPES      = 4,
    parameter int          PIPE_WIDTH   = 40,
    parameter int          SPACING      = 220,
    parameter int          SCREEN_W     = 800,
    parameter int          SPAWN_OFFSET = 80,
    parameter int          GAP_SIZE     = 150,
    parameter int          GAP_MIN_TOP  = 60,
    parameter int          GAP_MAX_TOP  = 320,
    parameter int          BIRD_X       = 200,
    parameter logic [9:0]  LFSR_SEED    = 10'h3FF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       halt,
    input  logic [3:0] speed,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic       pipe_pixel,
    output logic       pass_pulse,
    output logic [9:0] score,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam int               GAP_RANGE = GAP_MAX_TOP - GAP_MIN_TOP;
    localparam logic signed [11:0] WRAP    = 12'(N_PIPES * SPACING);
    localparam logic signed [11:0] PW_S    = 12'(PIPE_WIDTH);
    localparam logic signed [11:0] BX_S    = 12'(BIRD_X);

    state_t      state_q, state_d;
    logic [10:0] x_q   [N_PIPES];
    logic [9:0]  gap_q [N_PIPES];
    logic [9:0]  lfsr_q;
    logic [9:0]  score_q;
    logic        pass_q;
    logic        pix_q;

    logic [10:0]       x_next   [N_PIPES];
    logic [9:0]        gap_next [N_PIPES];
    logic [N_PIPES-1:0] crossed;
    logic [N_PIPES-1:0] hit;
    logic              move;
    logic              reinit;
    logic signed [11:0] spd_s;

    // Map a raw LFSR value into [GAP_MIN_TOP, GAP_MAX_TOP]: values above the
    // range fold back once, anything still too large is clamped.
    function automatic logic [9:0] fold(input logic [9:0] raw);
        logic [10:0] t;
        if ({1'b0, raw} <= 11'(GAP_RANGE))
            t = {1'b0, raw};
        else
            t = {1'b0, raw} - 11'(GAP_RANGE) - 11'd1;
        if (t > 11'(GAP_RANGE))
            t = 11'(GAP_RANGE);
        return 10'(11'(GAP_MIN_TOP) + t);
    endfunction

    function automatic logic [3:0] popcount(input logic [N_PIPES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < N_PIPES; k++)
            c = c + 4'(v[k]);
        return c;
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [3:0] b);
        logic [10:0] s;
        s = {1'b0, a} + 11'(b);
        return (s > 11'd999) ? 10'd999 : s[9:0];
    endfunction

    assign move   = (state_q == RUN) && frame_tick && !halt;
    assign reinit = (state_q == HALT) && start;
    assign spd_s  = $signed({8'b0, speed});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt)  state_d = HALT;
            HALT:    if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < N_PIPES; g++) begin : g_pipe
        localparam logic [9:0] MIX = 10'((g * 181) % 1024);
        logic signed [11:0] xs;
        logic signed [11:0] xm;
        logic               recycle;
        logic               in_h;
        logic               in_gap;

        assign xs      = $signed({1'b0, x_q[g]});
        assign xm      = xs - spd_s;
        assign recycle = (x_q[g] <= {7'b0, speed});
        // Wrapping by the full ring length keeps the inter-pipe spacing exact.
        assign x_next[g]   = recycle ? 11'(xm + WRAP) : 11'(xm);
        assign gap_next[g] = recycle ? fold(lfsr_q ^ MIX) : gap_q[g];
        // Trailing edge moves from right of BIRD_X to at-or-left of it.
        assign crossed[g]  = (xs + PW_S > BX_S) && (xm + PW_S <= BX_S);

        assign in_h   = ({1'b0, hCount} >= x_q[g]) &&
                        ({1'b0, hCount} <  x_q[g] + 11'(PIPE_WIDTH));
        assign in_gap = ({1'b0, vCount} >= {1'b0, gap_q[g]}) &&
                        ({1'b0, vCount} <  {1'b0, gap_q[g]} + 11'(GAP_SIZE));
        assign hit[g] = in_h && !in_gap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            score_q <= 10'd0;
            pass_q  <= 1'b0;
            pix_q   <= 1'b0;
            for (int k = 0; k < N_PIPES; k++) begin
                x_q[k]   <= 11'(SCREEN_W + SPAWN_OFFSET + k * SPACING);
                gap_q[k] <= 10'(GAP_MIN_TOP);
            end
        end else begin
            state_q <= state_d;
            pix_q   <= |hit;
            pass_q  <= move && (|crossed);
            if (reinit) begin
                lfsr_q  <= LFSR_SEED;
                score_q <= 10'd0;
                for (int k = 0; k < N_PIPES; k++) begin
                    x_q[k]   <= 11'(SCREEN_W + SPAWN_OFFSET + k * SPACING);
                    gap_q[k] <= 10'(GAP_MIN_TOP);
                end
            end else if (move) begin
                lfsr_q  <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
                score_q <= sat_add(score_q, popcount(crossed));
                for (int k = 0; k < N_PIPES; k++) begin
                    x_q[k]   <= x_next[k];
                    gap_q[k] <= gap_next[k];
                end
            end
        end
    end

    assign pipe_pixel = pix_q;
    assign pass_pulse = pass_q;
    assign score      = score_q;
    assign state      = state_q;

endmodule

// File: doc/pipe_field.md
Name: pipe_field

Overview:
- Parametrised, N-channel successor of the pipe renderer for the Flappy Bird VGA path.
- Scrolls N_PIPES obstacle pipes, one step per frame_tick, at a run-time speed.
- Recycles off-screen pipes with LFSR-derived gap heights, while holding exact spacing.
- Adds a game-state FSM (IDLE/RUN/HALT), pass detection against the bird column, a saturating score, and a registered pixel output for the colour mux.

Parameters:
N_PIPES, 4, number of pipe channels (1..8)
PIPE_WIDTH, 40, pipe width in pixels
SPACING, 220, horizontal distance between consecutive pipes; N_PIPES*SPACING >= SCREEN_W+PIPE_WIDTH and <= 2047
SCREEN_W, 800, scan width
SPAWN_OFFSET, 80, off-screen distance of pipe 0 at init
GAP_SIZE, 150, vertical opening height
GAP_MIN_TOP, 60, lowest allowed gap top
GAP_MAX_TOP, 320, highest allowed gap top; GAP_MAX_TOP+GAP_SIZE <= 480
BIRD_X, 200, bird column used for pass detection
LFSR_SEED, 10'h3FF, non-zero LFSR reset value

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame; the motion step
start  in  1  one-cycle command: IDLE->RUN, or HALT->IDLE (restart)
halt  in  1  one-cycle command (collision): RUN->HALT
speed  in  4  pixels moved per frame_tick; sampled on the tick
hCount  in  10  current scan column
vCount  in  10  current scan row
pipe_pixel  out  1  registered: current pixel lies on any pipe body
pass_pulse  out  1  one-cycle pulse when a pipe fully passes BIRD_X
score  out  10  pipes passed, saturates at 999
state  out  2  00 IDLE, 01 RUN, 10 HALT

Behaviour:
- Reset is clk, with reset asynchronous and active-high. On reset:
  - state=IDLE; x[i]=SCREEN_W+SPAWN_OFFSET+i*SPACING; gap_top[i]=GAP_MIN_TOP.
  - lfsr=LFSR_SEED; score=0; pass_pulse=0; pipe_pixel=0.
- Positions are 11 bits; gap_top is 10 bits.
- FSM:
  - IDLE: start -> RUN. halt is ignored.
  - RUN: halt -> HALT. If halt and start arrive together, halt wins.
  - HALT: start -> IDLE and re-initialises positions, gaps, score and LFSR to the reset values. halt is ignored.
- Motion: only in RUN, on frame_tick, and only when halt is not asserted in the same cycle. Halt wins, so that tick does not move.
- On a motion tick:
  - lfsr shifts once: {lfsr[8:0], lfsr[9]^lfsr[6]}.
  - Every pipe is updated in parallel from pre-tick values.
  - If x[i] > speed: x[i] <= x[i]-speed.
  - Otherwise (recycle): x[i] <= x[i]-speed+N_PIPES*SPACING, computed as signed 12-bit and then truncated. gap_top[i] <= fold(lfsr ^ MIX_i), using pre-shift lfsr and MIX_i = (i*10'h0B5) mod 1024.
- fold(raw), with R=GAP_MAX_TOP-GAP_MIN_TOP:
  - t = raw if raw<=R, else raw-R-1.
  - t is then clamped to R.
  - result = GAP_MIN_TOP+t.
- speed=0: no pipe moves and no recycle occurs; the LFSR still advances.
- Multiple pipes may recycle on the same tick; each uses its own MIX_i.
- Pass detection, per pipe on a motion tick: crossed_i = (x[i]+PIPE_WIDTH > BIRD_X) and (x[i]-speed+PIPE_WIDTH <= BIRD_X). Both terms use signed 12-bit, pre-wrap values.
- If any crossed_i:
  - pass_pulse=1 in the next cycle.
  - score += popcount(crossed), saturating at 999.
- pass_pulse is otherwise 0.
- Pixel, 1-cycle latency. pipe_pixel is registered as OR over i of:
  - hCount in [x[i], x[i]+PIPE_WIDTH), and
  - NOT vCount in [gap_top[i], gap_top[i]+GAP_SIZE).
- Compares use 11 bits with zero-extended counts.
- Pixel drawing is active in all states.
- State changes take effect in the cycle after the command.

Test Plan:
- Reset release -> x0=880, x3=1540, state=00, score=0; hCount=100, vCount=0 -> pipe_pixel=0.
- start, then 10 ticks at speed=2 -> x0=860, x1=1080; state=01.
- Preload x0=3, speed=4, lfsr=300, one tick:
  - x0=879.
  - gap_top0=60+(300-261)=99.
- Same setup with lfsr=700 -> gap_top0=320 (fold to 439, clamped to 260).
- x0=161, speed=1, tick -> pass_pulse high for exactly 1 cycle; score 0->1. Score preloaded at 999 stays 999.
- x0=300, gap_top0=60; pixel checks one cycle after each input:
  - (h300,v59) -> 1
  - (h300,v60) -> 0
  - (h300,v210) -> 1
  - (h340,v0) -> 0
- halt in RUN with simultaneous frame_tick -> no movement, state=10; further ticks do not move.
- start in HALT -> state=00, x0=880, score=0.
- Assert reset mid-RUN between ticks -> all outputs take reset values immediately (asynchronous).
